// File: rtl/seg7_pkg.sv
// Shared glyphs, defaults and slot type for the two-digit multiplexed 7-segment scanner.
// Glyphs are active-low {g,f,e,d,c,b,a}.
package seg7_pkg;

  localparam int DEF_REFRESH_DIV = 50000;
  localparam int DEF_BLINK_SLOTS = 250;

  localparam logic [6:0] GLYPH_0     = 7'b1000000;
  localparam logic [6:0] GLYPH_1     = 7'b1111001;
  localparam logic [6:0] GLYPH_2     = 7'b0100100;
  localparam logic [6:0] GLYPH_3     = 7'b0110000;
  localparam logic [6:0] GLYPH_4     = 7'b0011001;
  localparam logic [6:0] GLYPH_5     = 7'b0010010;
  localparam logic [6:0] GLYPH_6     = 7'b0000010;
  localparam logic [6:0] GLYPH_7     = 7'b1111000;
  localparam logic [6:0] GLYPH_8     = 7'b0000000;
  localparam logic [6:0] GLYPH_9     = 7'b0010000;
  localparam logic [6:0] GLYPH_DASH  = 7'b0111111;
  localparam logic [6:0] GLYPH_BLANK = 7'b1111111;

  typedef enum logic {
    SLOT_UNITS = 1'b0,
    SLOT_TENS  = 1'b1
  } slot_e;

endpackage

// File: rtl/seg7_dec.sv
// BCD to active-low 7-segment decoder; values above 9 show a dash.
// Purely combinational, no backpressure.
module seg7_dec
  import seg7_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = GLYPH_DASH;
    case (bcd)
      4'd0:    seg = GLYPH_0;
      4'd1:    seg = GLYPH_1;
      4'd2:    seg = GLYPH_2;
      4'd3:    seg = GLYPH_3;
      4'd4:    seg = GLYPH_4;
      4'd5:    seg = GLYPH_5;
      4'd6:    seg = GLYPH_6;
      4'd7:    seg = GLYPH_7;
      4'd8:    seg = GLYPH_8;
      4'd9:    seg = GLYPH_9;
      default: seg = GLYPH_DASH;
    endcase
  end

endmodule

// File: rtl/seg7_scan2.sv
// Two-digit scanned 7-segment driver with shadow digits, ghost guard, leading-zero blank and blink.
// Outputs registered (1-cycle latency from internal state); free-running, no backpressure.
module seg7_scan2
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV = DEF_REFRESH_DIV,
  parameter int BLINK_SLOTS = DEF_BLINK_SLOTS
) (
  input  logic       clki,
  input  logic       rs,
  input  logic [3:0] led1,
  input  logic [3:0] led2,
  input  logic       load,
  input  logic       blank_lz,
  input  logic       blink,
  output logic [6:0] seg,
  output logic [1:0] dig,
  output logic       digit_err
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int BW = (BLINK_SLOTS > 1) ? $clog2(BLINK_SLOTS) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_DIV - 1);
  localparam logic [BW-1:0] BCNT_LAST = BW'(BLINK_SLOTS - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  slot_e         slot_q, slot_d;
  logic          phase_q, phase_d;
  logic [3:0]    sh1_q, sh1_d, sh2_q, sh2_d;
  logic [6:0]    seg_q, seg_d;
  logic [1:0]    dig_q, dig_d;
  logic          err_q, err_d;

  logic          wrap;
  logic          off;
  logic [3:0]    cur_digit;
  logic [6:0]    dec_seg;

  seg7_dec u_dec (
    .bcd (cur_digit),
    .seg (dec_seg)
  );

  always_comb begin
    wrap    = (cnt_q == CNT_LAST);
    cnt_d   = wrap ? '0 : cnt_q + 1'b1;
    slot_d  = slot_q;
    bcnt_d  = bcnt_q;
    phase_d = phase_q;
    if (wrap) begin
      slot_d = (slot_q == SLOT_UNITS) ? SLOT_TENS : SLOT_UNITS;
      if (bcnt_q == BCNT_LAST) begin
        bcnt_d  = '0;
        phase_d = ~phase_q;
      end else begin
        bcnt_d = bcnt_q + 1'b1;
      end
    end

    sh1_d = load ? led1 : sh1_q;
    sh2_d = load ? led2 : sh2_q;

    // Display path reads only the shadows, so a load lands whole on the next frame.
    cur_digit = (slot_q == SLOT_TENS) ? sh2_q : sh1_q;
    off = (cnt_q == '0)
        | (blink & ~phase_q)
        | ((slot_q == SLOT_TENS) & blank_lz & (sh2_q == 4'd0));

    dig_d = off ? 2'b11 : ((slot_q == SLOT_TENS) ? 2'b01 : 2'b10);
    seg_d = off ? GLYPH_BLANK : dec_seg;
    err_d = (sh1_q > 4'd9) | (sh2_q > 4'd9);
  end

  always_ff @(posedge clki) begin
    if (rs) begin
      cnt_q   <= '0;
      bcnt_q  <= '0;
      slot_q  <= SLOT_UNITS;
      phase_q <= 1'b1;
      sh1_q   <= 4'd0;
      sh2_q   <= 4'd0;
      seg_q   <= GLYPH_BLANK;
      dig_q   <= 2'b11;
      err_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      bcnt_q  <= bcnt_d;
      slot_q  <= slot_d;
      phase_q <= phase_d;
      sh1_q   <= sh1_d;
      sh2_q   <= sh2_d;
      seg_q   <= seg_d;
      dig_q   <= dig_d;
      err_q   <= err_d;
    end
  end

  assign seg       = seg_q;
  assign dig       = dig_q;
  assign digit_err = err_q;

endmodule

// File: tb/tb_seg7_scan2.sv
// Scoreboard bench for seg7_scan2 with REFRESH_DIV=4, BLINK_SLOTS=2.
module tb_seg7_scan2;

  localparam int DIV = 4;
  localparam int BSL = 2;

  logic       clki;
  logic       rs;
  logic [3:0] led1, led2;
  logic       load, blank_lz, blink;
  logic [6:0] seg;
  logic [1:0] dig;
  logic       digit_err;

  seg7_scan2 #(.REFRESH_DIV(DIV), .BLINK_SLOTS(BSL)) dut (
    .clki      (clki),
    .rs        (rs),
    .led1      (led1),
    .led2      (led2),
    .load      (load),
    .blank_lz  (blank_lz),
    .blink     (blink),
    .seg       (seg),
    .dig       (dig),
    .digit_err (digit_err)
  );

  initial clki = 1'b0;
  always #5 clki = ~clki;

  typedef struct packed {
    logic [6:0] seg;
    logic [1:0] dig;
    logic       err;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_err    = 0;

  // Bench model: t counts edges since reset release; m1/m2 are the expected shadows.
  int         t;
  logic [3:0] m1, m2;

  logic [6:0] glyph [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                             7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                             7'b0000000, 7'b0010000, 7'b0111111, 7'b0111111,
                             7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111};

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, act, exp);
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    int   cnt, slot, wraps;
    bit   phase_on, off;
    e.err = (m1 > 4'd9) || (m2 > 4'd9);
    if (rs) begin
      e.seg = 7'h7F;
      e.dig = 2'b11;
      e.err = 1'b0;
      return e;
    end
    cnt      = t % DIV;
    wraps    = t / DIV;
    slot     = wraps % 2;
    phase_on = ((wraps / BSL) % 2) == 0;
    off      = (cnt == 0) || (blink && !phase_on) || (slot == 1 && blank_lz && m2 == 4'd0);
    e.dig    = off ? 2'b11 : ((slot == 1) ? 2'b01 : 2'b10);
    e.seg    = off ? 7'h7F : glyph[(slot == 1) ? m2 : m1];
    return e;
  endfunction

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clki);
      exp_q.push_back(model_out());
      @(posedge clki);
      #1;
      if (rs) begin
        t  = 0;
        m1 = 4'd0;
        m2 = 4'd0;
      end else begin
        t++;
        if (load) begin
          m1 = led1;
          m2 = led2;
        end
      end
    end
  endtask

  task automatic load_val(input logic [3:0] tens, input logic [3:0] units);
    led2 = tens;
    led1 = units;
    load = 1'b1;
    step(1);
    load = 1'b0;
  endtask

  always @(posedge clki) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("seg", 32'(seg), 32'(e.seg));
      check("dig", 32'(dig), 32'(e.dig));
      check("digit_err", 32'(digit_err), 32'(e.err));
    end
  end

  initial begin
    rs = 1'b1; led1 = 4'd0; led2 = 4'd0; load = 1'b0; blank_lz = 1'b0; blink = 1'b0;
    t = 0; m1 = 4'd0; m2 = 4'd0;

    step(2);
    rs = 1'b0;
    step(10);

    load_val(4'd4, 4'd7);
    step(16);

    blank_lz = 1'b1;
    load_val(4'd0, 4'd5);
    step(12);
    blank_lz = 1'b0;
    step(8);

    load_val(4'd0, 4'hC);
    step(8);
    load_val(4'd0, 4'd3);
    step(8);

    blink = 1'b1;
    step(40);
    blink = 1'b0;
    step(10);

    // Load landing exactly on a slot wrap.
    while ((t % DIV) != DIV - 1) step(1);
    load_val(4'd1, 4'd2);
    step(10);

    // Reset at refresh count 2 of the tens slot, with load held to show rs wins.
    load_val(4'd5, 4'd9);
    while ((t % (2 * DIV)) != DIV + 2) step(1);
    rs = 1'b1; load = 1'b1;
    step(1);
    rs = 1'b0; load = 1'b0;
    step(12);

    for (int k = 0; k < 40; k++) begin
      led1     = 4'($urandom_range(0, 15));
      led2     = 4'($urandom_range(0, 15));
      load     = ($urandom_range(0, 3) == 0);
      blank_lz = 1'($urandom_range(0, 1));
      blink    = ($urandom_range(0, 7) == 0);
      step(1);
    end
    load = 1'b0; blink = 1'b0; blank_lz = 1'b0;
    step(2);

    @(negedge clki);
    check("drain", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/seg7_scan2.md
SEG7_SCAN2 -- requirements
Module: seg7_scan2

Interface
REQ-001 Parameter REFRESH_DIV, default 50000, clki cycles per digit slot (legal range >= 2).
REQ-002 Parameter BLINK_SLOTS, default 250, digit slots per blink half-period (legal range >= 1).
REQ-003 clki  input  1  system clock; all state changes on its rising edge.
REQ-004 rs  input  1  reset, synchronous, active-high.
REQ-005 led1  input  4  BCD units digit from the mod-60 counter.
REQ-006 led2  input  4  BCD tens digit from the mod-60 counter.
REQ-007 load  input  1  when high at an edge, led1/led2 are captured into shadow registers.
REQ-008 blank_lz  input  1  when high, a zero tens digit is blanked.
REQ-009 blink  input  1  when high, the display flashes at the blink rate.
REQ-010 seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-011 dig  output  2  digit enables, active-low; dig[0] is units, dig[1] is tens.
REQ-012 digit_err  output  1  high while either shadow digit is greater than 9.

Function
REQ-013 A refresh counter shall count 0..REFRESH_DIV-1 and wrap to 0; slot shall toggle (0 = units, 1 = tens) on each wrap.
REQ-014 A shadow load shall take effect on the next edge; the display shall show only shadow values, never live inputs.
REQ-015 seg, dig and digit_err shall be registered, reflecting the internal state of the preceding cycle (1-cycle latency).
REQ-016 Ghost guard: dig shall be 2'b11 for the cycle corresponding to refresh count 0 of every slot.
REQ-017 Otherwise dig shall be 2'b10 in slot 0 and 2'b01 in slot 1.
REQ-018 seg shall carry the pattern of the selected shadow digit, using the standard 0-9 glyphs.
REQ-019 A digit value of 10-15 shall display as a dash (7'b0111111), and digit_err shall be 1 with the same latency.
REQ-020 If blank_lz=1 and shadow tens=0, dig shall stay 2'b11 throughout slot 1.
REQ-021 A blink phase bit shall toggle every BLINK_SLOTS slot wraps.
REQ-022 When blink=1 and phase=off, dig shall be 2'b11; when blink=0, the phase counter shall keep running but be ignored.
REQ-023 Whenever dig=2'b11, seg shall also be 7'h7F (all off).
REQ-024 If load coincides with a slot wrap, the newly captured values shall be shown from the next cycle; no mixed-digit frame is allowed.

Reset
REQ-025 On an rs edge: refresh count=0, slot=0, shadows=0, blink phase=on, seg=7'h7F, dig=2'b11, digit_err=0.
REQ-026 rs shall override load and apply even mid-slot; scanning shall resume from slot 0 with a ghost-guard cycle.

Structure
REQ-027 Package seg7_pkg shall hold the glyph constants (0-9, dash, blank) and the default REFRESH_DIV/BLINK_SLOTS values.
REQ-028 A sub-module seg7_dec shall be a combinational decoder: 4-bit BCD in, 7-bit active-low segments out, dash for values >9.
REQ-029 The refresh counter width shall be derived from REFRESH_DIV, with no truncation at the default value.

Verification (bench uses REFRESH_DIV=4, BLINK_SLOTS=2)
REQ-030 Reset: rs=1 for 2 edges -> seg=7'h7F, dig=2'b11, digit_err=0; after release the first ghost cycle is followed by dig=2'b10.
REQ-031 Display 47: load with led2=4, led1=7 -> slot 0 gives dig=2'b10, seg=7'b1111000; slot 1 gives dig=2'b01, seg=7'b0011001; each slot starts with one dig=2'b11 cycle.
REQ-032 Leading-zero blanking: led2=0, led1=5, blank_lz=1 -> units seg=7'b0010010; tens slot dig=2'b11 and seg=7'h7F; with blank_lz=0 the tens slot shows seg=7'b1000000.
REQ-033 Invalid digit: load led1=4'hC -> digit_err=1 within 2 edges, and the units slot shows seg=7'b0111111; a later load of led1=3 -> digit_err=0.
REQ-034 Blink: blink=1 -> dig alternates between 2 slots all-off and 2 slots scanning; blink=0 -> continuous scanning.
REQ-035 Reset mid-operation: rs pulsed at refresh count 2 of slot 1 with shadows holding 59 -> next edge outputs match the reset values, shadows=0, and the display shows 00.
